// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// Produces one result bit per clock; start/busy/done handshake, err flags invalid digits.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned WR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               bad_digit;
  logic [WR_W-1:0]    wr_sh;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         nib;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shift right, then pull each nibble back from >=8 by 3 (inverse of add-3).
  always_comb begin
    wr_sh   = {bcd_q, bin_q} >> 1;
    bcd_adj = wr_sh[WR_W-1:BIN_W];
    nib     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = bcd_adj[4*i +: 4];
      if (nib >= 4'd8) nib = nib - 4'd3;
      bcd_adj[4*i +: 4] = nib;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    bin_out_d = bin_out_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_digit) begin
            err_d     = 1'b1;
            bin_out_d = '0;
            done_d    = 1'b1;
          end else begin
            bcd_d   = bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = wr_sh[BIN_W-1:0];
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_out_d = wr_sh[BIN_W-1:0];
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      bin_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      bin_out_q <= bin_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: latency, results, error path, busy-start and reset abort.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept b at the next edge (E0), then check busy/done over E0..E11 and the result at E10.
  task automatic run_conv(input logic [11:0] b, input logic [9:0] expv, input string tag);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    start  = 1'b1;
    bcd_in = b;
    tick();
    start  = 1'b0;
    bcd_in = 12'hFFF;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (busy && done) check({tag, "_busy_and_done"}, 1, 0);
      if (k == 10) begin
        check({tag, "_done_at_E10"}, done, 1);
        check({tag, "_bin_out"}, bin_out, expv);
        check({tag, "_err"}, err, 0);
      end
    end
    check({tag, "_busy_cycles"}, busy_cnt, 10);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int done_cnt;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bin_out", bin_out, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    run_conv(12'h999, 10'h3E7, "c999");
    run_conv(12'h000, 10'h000, "c000");
    run_conv(12'h123, 10'h07B, "c123");
    run_conv(12'h080, 10'h050, "c080");

    // Error path: one-cycle completion, no busy.
    start  = 1'b1;
    bcd_in = 12'h1A5;
    tick();
    start  = 1'b0;
    check("e1A5_done", done, 1);
    check("e1A5_err", err, 1);
    check("e1A5_bin_out", bin_out, 0);
    check("e1A5_busy", busy, 0);
    tick();
    check("e1A5_done_drop", done, 0);
    check("e1A5_err_hold", err, 1);
    check("e1A5_busy_after", busy, 0);
    run_conv(12'h042, 10'h02A, "c042");

    // Start held high through busy: second request accepted only at E11.
    start  = 1'b1;
    bcd_in = 12'h500;
    tick();
    bcd_in = 12'h999;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 10) check("hold_busy", busy, 1);
    end
    check("hold_done500", done, 1);
    check("hold_bin500", bin_out, 10'h1F4);
    check("hold_busy_E10", busy, 0);
    tick();
    start = 1'b0;
    check("hold_accept_E11", busy, 1);
    check("hold_done_E11", done, 0);
    check("hold_bin_E11", bin_out, 10'h1F4);
    for (int k = 12; k <= 21; k++) tick();
    check("hold_done999", done, 1);
    check("hold_bin999", bin_out, 10'h3E7);

    // Reset mid-conversion: aborts with no done pulse.
    tick();
    start  = 1'b1;
    bcd_in = 12'h777;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bin_out", bin_out, 0);
    check("abort_err", err, 0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_bin_hold", bin_out, 0);
    run_conv(12'h256, 10'h100, "c256");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
